seq_mul16: RTL and testbench



---
 rtl/seq_mul_pkg.sv | 14 +
 rtl/seq_mul16_mul_add_2w.sv | 26 ++
 rtl/seq_mul16.sv | 132 +++++++++++++
 tb/tb_seq_mul16.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   - state_e : FSM state encoding (IDLE / RUN / DONE)
//   - SEQ_MUL_WIDTH : default operand width
package seq_mul_pkg;

  localparam int SEQ_MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mul16_mul_add_2w.sv
// mul_add_2w: combinational 2*WIDTH-bit adder, carry-in 0, carry-out dropped.
// Built as two WIDTH-bit halves with the low-half carry chained into the high half.
// Ports:
//   op_a  in  2*WIDTH  addend
//   op_b  in  2*WIDTH  addend
//   sum   out 2*WIDTH  op_a + op_b (mod 2^(2*WIDTH))
module mul_add_2w #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] op_a,
  input  logic [2*WIDTH-1:0] op_b,
  output logic [2*WIDTH-1:0] sum
);

  logic [WIDTH-1:0] sum_lo;
  logic [WIDTH-1:0] sum_hi;
  logic             carry_lo;

  always_comb begin
    {carry_lo, sum_lo} = {1'b0, op_a[WIDTH-1:0]} + {1'b0, op_b[WIDTH-1:0]};
    // Upper carry-out is discarded; the multiplier's accumulator never overflows.
    sum_hi = op_a[2*WIDTH-1:WIDTH] + op_b[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, carry_lo};
    sum    = {sum_hi, sum_lo};
  end

endmodule

// File: rtl/seq_mul16.sv
// seq_mul16: sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One partial-product add per clock; WIDTH-cycle latency in the default build.
// Optional macro SEQ_MUL16_EARLY_TERM_EN: leave RUN as soon as the shifted
// multiplier is zero (latency = index of highest set bit of b, plus 1; minimum 1).
// Ports:
//   clk      in   1        rising-edge clock
//   reset    in   1        asynchronous active-high reset
//   start    in   1        request; sampled only when not busy
//   a        in   WIDTH    multiplicand, captured on accepted start
//   b        in   WIDTH    multiplier, captured on accepted start
//   busy     out  1        high in RUN
//   done     out  1        one-cycle pulse, product valid
//   product  out  2*WIDTH  result; held until next completion or reset
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one shift-and-add step per clock
// DONE    | product just updated; done=1; start here reloads immediately
module seq_mul16
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_shr;
  logic               last_iter;

  mul_add_2w #(.WIDTH(WIDTH)) u_add (
    .op_a (acc_q),
    .op_b (mcand_q),
    .sum  (sum)
  );

  always_comb begin
    mplier_shr = mplier_q >> 1;
    acc_next   = mplier_q[0] ? sum : acc_q;
`ifdef SEQ_MUL16_EARLY_TERM_EN
    // Once no multiplier bits remain, further iterations would add nothing.
    last_iter  = (cnt_q == CNT_LAST) || (mplier_shr == '0);
`else
    last_iter  = (cnt_q == CNT_LAST);
`endif

    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          cnt_d    = '0;
          state_d  = ST_RUN;
          busy_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          product_d = acc_next;
          state_d   = ST_DONE;
          done_d    = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mul16.sv
module tb_seq_mul16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[10];

  seq_mul16 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected cycles from accepted start to done.
  function automatic int exp_lat(input logic [15:0] bv);
`ifdef SEQ_MUL16_EARLY_TERM_EN
    if (bv == 16'd0) return 1;
    for (int i = 15; i >= 0; i--)
      if (bv[i]) return i + 1;
    return 1;
`else
    return 16;
`endif
  endfunction

  // Called at the negedge right after the accepting edge; returns at the done negedge.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input logic [15:0] va, input logic [15:0] vb, input logic [31:0] vp,
                         input string name);
    int lat, bcnt;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk({name, " product"}, product, vp);
    chk({name, " latency"}, lat, exp_lat(vb));
    chk({name, " busy cycles"}, bcnt, exp_lat(vb));
    @(negedge clk);
    chk({name, " done single pulse"}, {31'd0, done}, 32'd0);
    chk({name, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat, bcnt, pulse_at, rst_at, ndone, lat2;

    vecs[0] = '{16'd3,     16'd5,     32'h0000000F};
    vecs[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001};
    vecs[2] = '{16'h0000,  16'h1234,  32'h00000000};
    vecs[3] = '{16'h1234,  16'h0000,  32'h00000000};
    vecs[4] = '{16'h0001,  16'hFFFF,  32'h0000FFFF};
    vecs[5] = '{16'hFFFF,  16'h0001,  32'h0000FFFF};
    vecs[6] = '{16'h8000,  16'h8000,  32'h40000000};
    vecs[7] = '{16'd3,     16'h8000,  32'h00018000};
    vecs[8] = '{16'd255,   16'd255,   32'd65025};
    vecs[9] = '{16'd100,   16'd100,   32'd10000};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    #23;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset product", product, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // start while busy must be ignored
    @(negedge clk);
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulse_at = (exp_lat(16'd9) - 2 < 5) ? exp_lat(16'd9) - 2 : 5;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (lat == pulse_at) begin a = 16'd2; b = 16'd2; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("ignored start product", product, 32'd63);
    chk("ignored start latency", lat, exp_lat(16'd9));
    @(negedge clk);
    chk("ignored start idle", {30'd0, busy, done}, 32'd0);

    // reset mid-operation aborts without a done pulse
    @(negedge clk);
    a = 16'd100; b = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_at = (exp_lat(16'd100) > 8) ? 8 : exp_lat(16'd100) - 3;
    ndone = 0;
    for (int k = 0; k < rst_at; k++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort product", product, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort no done", ndone, 0);
    run_vec(16'd100, 16'd100, 32'd10000, "after abort");

    // start held high: back-to-back with operands changed in the DONE cycle
    @(negedge clk);
    a = 16'd2; b = 16'd3; start = 1'b1;
    @(negedge clk);
    wait_done(lat, bcnt);
    chk("b2b first product", product, 32'd6);
    chk("b2b first latency", lat, exp_lat(16'd3));
    a = 16'd4; b = 16'd5;
    @(negedge clk);
    lat2 = 1;
    while (done !== 1'b1 && lat2 < 60) begin
      @(negedge clk);
      lat2++;
    end
    start = 1'b0;
    chk("b2b second product", product, 32'd20);
    chk("b2b done spacing", lat2, exp_lat(16'd5) + 1);
    @(negedge clk);
    chk("b2b end done low", {31'd0, done}, 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
